// File: rtl/simon_host_pkg.sv
// simon_host_pkg: shared state encoding and timeout sizing for the SIMON host controller
package simon_host_pkg;

    typedef enum logic [2:0] {IDLE, KREQ, KWAIT, DREQ, DWAIT, READ, RDROP} state_t;

    localparam int TMO_W = 8;

    function automatic logic timed(input state_t s);
        return s inside {KREQ, KWAIT, DREQ, DWAIT, RDROP};
    endfunction

endpackage

// File: rtl/simon_host_outbuf.sv
// simon_host_outbuf: one-entry valid/ready result register
module simon_host_outbuf #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         nR,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    // load fills the entry; a downstream handshake empties it
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= load | (out_valid & ~out_ready);
            if (load) out_data <= din;
        end
    end

endmodule

// File: rtl/simon_host_ctrl.sv
// simon_host_ctrl: host-side initiator sequencing keys and blocks into one SIMON core
module simon_host_ctrl
    import simon_host_pkg::*;
#(
    parameter int N   = 24,
    parameter int M   = 3,
    parameter int TMO = 255
) (
    input  logic           clk,
    input  logic           nR,
    input  logic           key_valid,
    output logic           key_ready,
    input  logic [M*N-1:0] key_in,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] in_block,
    input  logic           in_enc_dec,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_block,
    output logic           err,
    output logic           newKey,
    output logic           newData,
    output logic           readData,
    output logic           enc_dec,
    output logic [M*N-1:0] KEY,
    output logic [2*N-1:0] BLOCK,
    input  logic           loadKey,
    input  logic           doneKey,
    input  logic           loadData,
    input  logic           doneData,
    input  logic [2*N-1:0] outData
);

    state_t           state, nxt;
    logic [TMO_W-1:0] cnt;
    logic             key_loaded;
    logic             counting;
    logic             tmo;

    // a finished result stuck behind a full output register is not the core's fault
    assign counting = timed(state) & ~(state == DWAIT & doneData & out_valid);

    // next state, handshake strobes and timeout abort
    always_comb begin
        nxt       = state;
        key_ready = 1'b0;
        in_ready  = 1'b0;
        newKey    = state == KREQ;
        newData   = state == DREQ;
        readData  = (state == READ) | (state == RDROP);
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                key_ready = key_valid;
                in_ready  = ~key_valid & in_valid & key_loaded;
                nxt       = key_valid ? KREQ : in_ready ? DREQ : IDLE;
            end
            KREQ:    nxt = loadKey ? KWAIT : KREQ;
            KWAIT:   nxt = doneKey ? IDLE : KWAIT;
            DREQ:    nxt = loadData ? DWAIT : DREQ;
            DWAIT:   nxt = (doneData & (~out_valid | out_ready)) ? READ : DWAIT;
            READ:    nxt = RDROP;
            RDROP:   nxt = doneData ? RDROP : IDLE;
            default: nxt = IDLE;
        endcase
        tmo = counting & (nxt == state) & (cnt == TMO_W'(TMO - 1));
        if (tmo) nxt = IDLE;
    end

    // state register, per-state timeout counter and sticky flags
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            state      <= IDLE;
            cnt        <= '0;
            key_loaded <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= nxt;
            cnt        <= (nxt != state) ? '0 : (counting & ~&cnt) ? cnt + 1'b1 : cnt;
            key_loaded <= tmo ? 1'b0 : (state == KWAIT & doneKey) ? 1'b1 : key_loaded;
            err        <= err | tmo;
        end
    end

    // key and block toward the core change only on an upstream accept
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            KEY     <= '0;
            BLOCK   <= '0;
            enc_dec <= 1'b0;
        end else begin
            if (key_ready) KEY <= key_in;
            if (in_ready) begin
                BLOCK   <= in_block;
                enc_dec <= in_enc_dec;
            end
        end
    end

    simon_host_outbuf #(.W(2*N)) u_outbuf (
        .clk       (clk),
        .nR        (nR),
        .load      (state == READ),
        .din       (outData),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_block)
    );

endmodule

// File: tb/tb_simon_host_ctrl.sv
// tb_simon_host_ctrl: directed bench with a behavioural SIMON core stub
module tb_simon_host_ctrl;
    import simon_host_pkg::*;

    localparam logic [71:0] K0 = 72'h121110_0A0908_020100;
    localparam logic [47:0] PT = 48'h6120676E696C;
    localparam logic [47:0] CT = 48'hDAE5AC292CAC;

    logic        clk = 1'b0;
    logic        nR;
    logic        key_valid, key_ready, in_valid, in_ready, in_enc_dec;
    logic        out_valid, out_ready, err;
    logic [71:0] key_in, KEY;
    logic [47:0] in_block, out_block, BLOCK, outData;
    logic        newKey, newData, readData, enc_dec;
    logic        loadKey, doneKey, loadData, doneData;

    int n_chk = 0;
    int n_pass = 0;

    bit          no_load;
    int          ks, ds, kc, dc;
    logic [47:0] s_blk;
    logic        s_enc;
    logic [71:0] s_key;

    logic [47:0] bv [5] = '{48'h000000000001, 48'h123456789ABC, 48'hFFFFFFFFFFFF, 48'hAAAAAA555555, 48'h123456ABCDEF};
    logic        ev [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [47:0] xv [5] = '{48'hFFFFFFFFFFFE, 48'hEDCBA9876543, 48'h000000000000, 48'h555555AAAAAA, 48'hABCDEF123456};

    simon_host_ctrl #(.N(24), .M(3), .TMO(255)) dut (
        .clk(clk), .nR(nR),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block), .in_enc_dec(in_enc_dec),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .err(err),
        .newKey(newKey), .newData(newData), .readData(readData), .enc_dec(enc_dec),
        .KEY(KEY), .BLOCK(BLOCK),
        .loadKey(loadKey), .doneKey(doneKey), .loadData(loadData), .doneData(doneData),
        .outData(outData)
    );

    always #5 clk = ~clk;

    // the known SIMON 48/72 pair, plus an easy transform for every other block
    function automatic logic [47:0] core_model(input logic [71:0] k, input logic [47:0] b, input logic e);
        if (k == K0 && b == PT && e) return CT;
        if (k == K0 && b == CT && !e) return PT;
        return e ? ~b : {b[23:0], b[47:24]};
    endfunction

    // core stub: slow load acknowledge, fixed compute delay, doneData held until readData
    always @(negedge clk) begin
        if (!nR) begin
            ks = 0; ds = 0; kc = 0; dc = 0;
            loadKey = 0; doneKey = 0; loadData = 0; doneData = 0; outData = '0;
        end else begin
            doneKey = 0;
            case (ks)
                0: if (newKey) begin ks = 1; kc = 0; end
                1: begin kc++; if (kc == 2) begin loadKey = 1; s_key = KEY; ks = 2; end end
                2: if (!newKey) begin loadKey = 0; kc = 0; ks = 3; end
                3: begin kc++; if (kc == 3) begin doneKey = 1; ks = 0; end end
                default: ks = 0;
            endcase
            case (ds)
                0: if (newData && !no_load) begin ds = 1; dc = 0; end
                1: begin dc++; if (dc == 2) begin loadData = 1; s_blk = BLOCK; s_enc = enc_dec; ds = 2; end end
                2: if (!newData) begin loadData = 0; dc = 0; ds = 3; end
                3: begin dc++; if (dc == 4) begin outData = core_model(s_key, s_blk, s_enc); doneData = 1; ds = 4; end end
                4: if (readData) ds = 5;
                5: begin doneData = 0; ds = 0; end
                default: ds = 0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic send_key(input logic [71:0] k);
        int n = 0;
        tick;
        key_in = k;
        key_valid = 1;
        #1;
        while (!key_ready && n < 600) begin tick; n++; end
        chk("key_accept", key_ready, 1);
        @(posedge clk);
        #1 key_valid = 0;
    endtask

    task automatic send_block(input logic [47:0] b, input logic e);
        int n = 0;
        tick;
        in_block = b;
        in_enc_dec = e;
        in_valid = 1;
        #1;
        while (!in_ready && n < 600) begin tick; n++; end
        chk("in_accept", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic get_result(output logic [47:0] r);
        int n = 0;
        tick;
        while (!out_valid && n < 600) begin tick; n++; end
        chk("out_wait", out_valid, 1);
        r = out_block;
        out_ready = 1;
        @(posedge clk);
        #1 out_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] r, rb;
        bit bad, dk;
        int n;
        nR = 0; key_valid = 0; in_valid = 0; in_enc_dec = 0; out_ready = 0;
        key_in = '0; in_block = '0; no_load = 0;
        repeat (3) tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_ctrl", {newKey, newData, readData, enc_dec, key_ready, in_ready}, 0);
        chk("rst_key", KEY, 0);
        chk("rst_block", BLOCK, 0);
        chk("rst_out_block", out_block, 0);
        chk("rst_state", dut.state, IDLE);
        nR = 1;

        // block offered before any key: in_ready must wait for doneKey
        tick;
        in_block = PT; in_enc_dec = 1; in_valid = 1;
        bad = 0;
        repeat (5) begin tick; bad |= in_ready; end
        key_in = K0; key_valid = 1;
        #1;
        chk("key_prio_ready", key_ready, 1);
        chk("key_prio_in", in_ready, 0);
        @(posedge clk);
        #1 key_valid = 0;
        dk = 0; n = 0;
        while (!in_ready && n < 200) begin
            tick;
            if (in_ready && !dk) bad = 1;
            dk |= doneKey;
            n++;
        end
        chk("in_ready_pre_key", bad, 0);
        chk("donekey_seen", dk, 1);
        chk("in_ready_post_key", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
        tick;
        chk("accept_to_newData", newData, 1);
        chk("core_block", BLOCK, PT);
        chk("core_key", KEY, K0);
        chk("core_enc", enc_dec, 1);
        n = 0;
        while (!doneData && n < 200) begin tick; n++; end
        n = 0;
        while (!out_valid && n < 10) begin tick; n++; end
        chk("done_to_out_valid", n, 2);
        chk("enc_block", out_block, CT);
        chk("enc_err", err, 0);
        get_result(r);
        chk("enc_result", r, CT);

        // decrypt with the same key
        send_block(CT, 0);
        get_result(r);
        chk("dec_result", r, PT);

        // five blocks with downstream stalled for 40 cycles
        fork
            begin
                for (int i = 0; i < 5; i++) send_block(bv[i], ev[i]);
            end
            begin
                repeat (40) tick;
                chk("stall_state", dut.state, DWAIT);
                chk("stall_out_valid", out_valid, 1);
                chk("stall_first", out_block, xv[0]);
                for (int i = 0; i < 5; i++) begin
                    get_result(rb);
                    chk("b2b_result", rb, xv[i]);
                end
            end
        join

        // core never acknowledges data: timeout after 255 cycles
        no_load = 1;
        send_block(48'h0, 1);
        n = 0;
        for (int m = 0; m < 400 && !err; m++) begin
            tick;
            if (newData) n++;
        end
        chk("tmo_cycles", n, 255);
        chk("tmo_err", err, 1);
        chk("tmo_newData", newData, 0);
        chk("tmo_state", dut.state, IDLE);
        in_valid = 1;
        #1;
        chk("tmo_key_cleared", in_ready, 0);
        in_valid = 0;
        no_load = 0;

        // reset pulsed while waiting for the core result
        send_key(K0);
        send_block(PT, 1);
        n = 0;
        while (dut.state != DWAIT && n < 100) begin tick; n++; end
        chk("reach_dwait", dut.state, DWAIT);
        nR = 0;
        #1;
        chk("mid_rst_err", err, 0);
        chk("mid_rst_ctrl", {newKey, newData, readData, enc_dec, out_valid}, 0);
        chk("mid_rst_block", BLOCK, 0);
        chk("mid_rst_key", KEY, 0);
        chk("mid_rst_state", dut.state, IDLE);
        tick;
        tick;
        nR = 1;
        send_key(K0);
        send_block(PT, 1);
        get_result(r);
        chk("post_rst_result", r, CT);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
